// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the minutes:seconds countdown timer.
// Holds the FSM state encoding and the wrap-around field step helper.
package clock_pkg;

  localparam int TIME_W = 6;

  typedef logic [1:0] state_t;

  localparam state_t ST_SET   = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam logic [TIME_W-1:0] SEC_MAX = TIME_W'(59);

  // One edit step on a time field that wraps between 0 and top in both directions.
  function automatic logic [TIME_W-1:0] wrap_step(
    input logic [TIME_W-1:0] val,
    input logic [TIME_W-1:0] top,
    input logic              up
  );
    if (up) begin
      return (val >= top) ? '0 : val + TIME_W'(1);
    end
    return (val == '0) ? top : val - TIME_W'(1);
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Front-panel bundle of the countdown timer: switches and buttons in, display and alarm out.
// The master side is the board (or bench), the slave side is the timer.
interface countdown_timer_if;
  import clock_pkg::*;

  logic              mode;
  logic              sel_field;
  logic              btn_inc_n;
  logic              btn_dec_n;
  logic              btn_start_n;
  logic [TIME_W-1:0] seconds;
  logic [TIME_W-1:0] minutes;
  logic              running;
  logic              alarm;
  logic              expired;

  modport master (
    output mode, sel_field, btn_inc_n, btn_dec_n, btn_start_n,
    input  seconds, minutes, running, alarm, expired
  );

  modport slave (
    input  mode, sel_field, btn_inc_n, btn_dec_n, btn_start_n,
    output seconds, minutes, running, alarm, expired
  );
endinterface

// File: rtl/countdown_timer_btn_edge.sv
// Two-flop synchroniser for an active-low asynchronous input plus a one-cycle
// pulse on the falling edge of the synchronised level; all flops release high.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic sync_n,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = btn_n;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_n = sync_q;
  assign fall   = prev_q & ~sync_q;

endmodule

// File: rtl/countdown_timer.sv
// Minutes:seconds countdown timer with button-edited preset, pause/resume and alarm.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the preset and keep running on expiry.
module countdown_timer
  import clock_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int MAX_MIN = 59
) (
  input  logic             clk,
  input  logic             rst_n,
  countdown_timer_if.slave bus
);

  localparam int                PRESC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);
  localparam logic [TIME_W-1:0]  MIN_MAX   = TIME_W'(MAX_MIN);

  // Bit 3 carries the inverted mode switch so its released level is "mode low".
  logic [3:0] raw_n;
  logic [3:0] sync_n;
  logic [3:0] fall;

  assign raw_n = {~bus.mode, bus.btn_start_n, bus.btn_dec_n, bus.btn_inc_n};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      btn_edge u_btn_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_n  (raw_n[gi]),
        .sync_n (sync_n[gi]),
        .fall   (fall[gi])
      );
    end
  endgenerate

  logic inc_p, dec_p, start_p, mode_sync;
  logic unused_sync;

  assign inc_p       = fall[0];
  assign dec_p       = fall[1];
  assign start_p     = fall[2];
  assign mode_sync   = ~sync_n[3];
  assign unused_sync = &{sync_n[2:0], fall[3]};

  state_t             state_q, state_d;
  logic [TIME_W-1:0]  sec_q, sec_d;
  logic [TIME_W-1:0]  min_q, min_d;
  logic [TIME_W-1:0]  pre_sec_q, pre_sec_d;
  logic [TIME_W-1:0]  pre_min_q, pre_min_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               expired_q, expired_d;

  logic              tick;
  logic              time_zero;
  logic              tick_zero;
  logic [TIME_W-1:0] tick_sec;
  logic [TIME_W-1:0] tick_min;

  // Time after one second has elapsed, borrowing a minute when seconds are exhausted.
  always_comb begin
    tick      = (presc_q == PRESC_MAX);
    time_zero = (sec_q == '0) && (min_q == '0);
    tick_sec  = sec_q - TIME_W'(1);
    tick_min  = min_q;
    if (sec_q == '0) begin
      tick_sec = SEC_MAX;
      tick_min = min_q - TIME_W'(1);
    end
    tick_zero = (tick_sec == '0) && (tick_min == '0);
  end

  always_comb begin
    state_d   = state_q;
    sec_d     = sec_q;
    min_d     = min_q;
    pre_sec_d = pre_sec_q;
    pre_min_d = pre_min_q;
    presc_d   = presc_q;
    expired_d = 1'b0;

    if (mode_sync && (state_q != ST_SET)) begin
      state_d = ST_SET;
      presc_d = '0;
    end else begin
      case (state_q)
        ST_SET: begin
          // A start press always wins over an edit landing in the same cycle.
          if (start_p) begin
            if (!mode_sync && !time_zero) begin
              state_d   = ST_RUN;
              pre_sec_d = sec_q;
              pre_min_d = min_q;
              presc_d   = '0;
            end
          end else if (inc_p != dec_p) begin
            if (bus.sel_field) begin
              min_d = wrap_step(min_q, MIN_MAX, inc_p);
            end else begin
              sec_d = wrap_step(sec_q, SEC_MAX, inc_p);
            end
          end
        end
        ST_RUN: begin
          if (start_p) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            presc_d = '0;
            if (tick_zero) begin
              expired_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              sec_d = pre_sec_q;
              min_d = pre_min_q;
`else
              sec_d   = '0;
              min_d   = '0;
              state_d = ST_DONE;
`endif
            end else begin
              sec_d = tick_sec;
              min_d = tick_min;
            end
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
        end
        ST_PAUSE: begin
          if (start_p) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (start_p) begin
            state_d = ST_SET;
            sec_d   = pre_sec_q;
            min_d   = pre_min_q;
          end
        end
        default: begin
          state_d = ST_SET;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_SET;
      sec_q     <= '0;
      min_q     <= '0;
      pre_sec_q <= '0;
      pre_min_q <= '0;
      presc_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      pre_sec_q <= pre_sec_d;
      pre_min_q <= pre_min_d;
      presc_q   <= presc_d;
      expired_q <= expired_d;
    end
  end

  assign bus.seconds = sec_q;
  assign bus.minutes = min_q;
  assign bus.running = (state_q == ST_RUN);
  assign bus.expired = expired_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  assign bus.alarm   = expired_q;
`else
  assign bus.alarm   = (state_q == ST_DONE);
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer at CLK_HZ = 10: drives on negedge, samples on negedge.
// Observed word is {minutes, seconds, running, alarm, expired}.
module tb_countdown_timer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  countdown_timer_if bus();

  countdown_timer #(
    .CLK_HZ  (10),
    .MAX_MIN (59)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [14:0] obs;
  logic [14:0] want;

  assign obs = {bus.minutes, bus.seconds, bus.running, bus.alarm, bus.expired};

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 = inc, 1 = dec, 2 = start, 3 = inc and dec together.
  // Returns on the negedge right after the press has been acted on.
  task automatic press(input int which);
    bus.btn_inc_n   = !(which == 0 || which == 3);
    bus.btn_dec_n   = !(which == 1 || which == 3);
    bus.btn_start_n = !(which == 2);
    idle(3);
    bus.btn_inc_n   = 1'b1;
    bus.btn_dec_n   = 1'b1;
    bus.btn_start_n = 1'b1;
  endtask

  task automatic test_reset();
    idle(2);
    want = 15'd0;
    checks++;
    if (obs !== want) begin errors++; $display("FAIL reset got=%h want=%h", obs, want); end
    else $display("ok   reset %h", obs);
    rst_n = 1'b1;
    idle(3);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL post_reset got=%h want=%h", obs, want); end
    else $display("ok   post_reset %h", obs);
  endtask

  task automatic test_load();
    bus.sel_field = 1'b0;
    for (int i = 0; i < 3; i++) begin press(0); idle(1); end
    bus.sel_field = 1'b1;
    press(0);
    idle(1);
    want = {6'd1, 6'd3, 3'b000};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL load_0103 got=%h want=%h", obs, want); end
    else $display("ok   load_0103 %h", obs);
  endtask

  task automatic test_run_to_done();
    press(2);
    want = {6'd1, 6'd3, 3'b100};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL run_start got=%h want=%h", obs, want); end
    else $display("ok   run_start %h", obs);
    idle(10);
    want = {6'd1, 6'd2, 3'b100};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL run_first_tick got=%h want=%h", obs, want); end
    else $display("ok   run_first_tick %h", obs);
    idle(30);
    want = {6'd0, 6'd59, 3'b100};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL run_borrow got=%h want=%h", obs, want); end
    else $display("ok   run_borrow %h", obs);
    idle(589);
    want = {6'd0, 6'd1, 3'b100};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL run_last_second got=%h want=%h", obs, want); end
    else $display("ok   run_last_second %h", obs);
    idle(1);
    want = {6'd0, 6'd0, 3'b011};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL expire_pulse got=%h want=%h", obs, want); end
    else $display("ok   expire_pulse %h", obs);
    idle(1);
    want = {6'd0, 6'd0, 3'b010};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL expire_once got=%h want=%h", obs, want); end
    else $display("ok   expire_once %h", obs);
    idle(20);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL done_hold got=%h want=%h", obs, want); end
    else $display("ok   done_hold %h", obs);
  endtask

  task automatic test_done_restart();
    idle(1);
    press(2);
    want = {6'd1, 6'd3, 3'b000};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL done_reload got=%h want=%h", obs, want); end
    else $display("ok   done_reload %h", obs);
    idle(2);
  endtask

  task automatic test_set_wrap();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    bus.sel_field = 1'b0;
    press(1);
    want = {6'd0, 6'd59, 3'b000};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL sec_dec_wrap got=%h want=%h", obs, want); end
    else $display("ok   sec_dec_wrap %h", obs);
    idle(1);
    bus.sel_field = 1'b1;
    press(1);
    want = {6'd59, 6'd59, 3'b000};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL min_dec_wrap got=%h want=%h", obs, want); end
    else $display("ok   min_dec_wrap %h", obs);
    idle(1);
    bus.sel_field = 1'b0;
    press(0);
    want = {6'd59, 6'd0, 3'b000};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL sec_inc_wrap got=%h want=%h", obs, want); end
    else $display("ok   sec_inc_wrap %h", obs);
    idle(1);
    press(3);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL inc_dec_cancel got=%h want=%h", obs, want); end
    else $display("ok   inc_dec_cancel %h", obs);
    idle(1);
    bus.sel_field = 1'b1;
    press(0);
    want = {6'd0, 6'd0, 3'b000};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL min_inc_wrap got=%h want=%h", obs, want); end
    else $display("ok   min_inc_wrap %h", obs);
    idle(1);
    press(2);
    idle(20);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL start_at_zero got=%h want=%h", obs, want); end
    else $display("ok   start_at_zero %h", obs);
  endtask

  task automatic test_pause();
    bus.sel_field = 1'b0;
    press(0);
    idle(1);
    press(0);
    idle(1);
    press(2);
    want = {6'd0, 6'd2, 3'b100};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL pause_run got=%h want=%h", obs, want); end
    else $display("ok   pause_run %h", obs);
    idle(3);
    press(2);
    want = {6'd0, 6'd2, 3'b000};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL pause_enter got=%h want=%h", obs, want); end
    else $display("ok   pause_enter %h", obs);
    idle(100);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL pause_frozen got=%h want=%h", obs, want); end
    else $display("ok   pause_frozen %h", obs);
    press(2);
    want = {6'd0, 6'd2, 3'b100};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL resume got=%h want=%h", obs, want); end
    else $display("ok   resume %h", obs);
    idle(4);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL resume_pre_tick got=%h want=%h", obs, want); end
    else $display("ok   resume_pre_tick %h", obs);
    idle(1);
    want = {6'd0, 6'd1, 3'b100};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL resume_tick got=%h want=%h", obs, want); end
    else $display("ok   resume_tick %h", obs);
    idle(10);
    want = {6'd0, 6'd0, 3'b011};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL pause_expire got=%h want=%h", obs, want); end
    else $display("ok   pause_expire %h", obs);
    idle(1);
  endtask

  task automatic test_reset_mid_run();
    press(2);
    want = {6'd0, 6'd2, 3'b000};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL reload_0002 got=%h want=%h", obs, want); end
    else $display("ok   reload_0002 %h", obs);
    idle(1);
    press(2);
    idle(3);
    want = {6'd0, 6'd2, 3'b100};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL pre_reset_run got=%h want=%h", obs, want); end
    else $display("ok   pre_reset_run %h", obs);
    rst_n = 1'b0;
    idle(1);
    want = 15'd0;
    checks++;
    if (obs !== want) begin errors++; $display("FAIL reset_mid_run got=%h want=%h", obs, want); end
    else $display("ok   reset_mid_run %h", obs);
    rst_n = 1'b1;
    idle(12);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL reset_stays_set got=%h want=%h", obs, want); end
    else $display("ok   reset_stays_set %h", obs);
  endtask

  task automatic test_mode_run();
    bus.sel_field = 1'b0;
    for (int i = 0; i < 3; i++) begin press(0); idle(1); end
    press(2);
    idle(12);
    want = {6'd0, 6'd2, 3'b100};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL mode_pre_run got=%h want=%h", obs, want); end
    else $display("ok   mode_pre_run %h", obs);
    bus.mode = 1'b1;
    idle(3);
    want = {6'd0, 6'd2, 3'b000};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL mode_to_set got=%h want=%h", obs, want); end
    else $display("ok   mode_to_set %h", obs);
    idle(20);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL mode_time_held got=%h want=%h", obs, want); end
    else $display("ok   mode_time_held %h", obs);
    bus.mode = 1'b0;
    idle(3);
  endtask

  task automatic test_hold();
    bus.sel_field = 1'b0;
    bus.btn_inc_n = 1'b0;
    idle(50);
    want = {6'd0, 6'd3, 3'b000};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL hold_one_step got=%h want=%h", obs, want); end
    else $display("ok   hold_one_step %h", obs);
    bus.btn_inc_n = 1'b1;
    idle(3);
    checks++;
    if (obs !== want) begin errors++; $display("FAIL hold_release got=%h want=%h", obs, want); end
    else $display("ok   hold_release %h", obs);
  endtask

  initial begin
    bus.mode        = 1'b0;
    bus.sel_field   = 1'b0;
    bus.btn_inc_n   = 1'b1;
    bus.btn_dec_n   = 1'b1;
    bus.btn_start_n = 1'b1;
    test_reset();
    test_load();
    test_run_to_done();
    test_done_restart();
    test_set_wrap();
    test_pause();
    test_reset_mid_run();
    test_mode_run();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
